// File: rtl/bus_copy_dma_pkg.sv
// Shared bus definitions for the copy DMA: bus widths, timeout default and FSM encoding.
package bus_copy_dma_pkg;
  localparam int ADDR_W                 = 16;
  localparam int DATA_W                 = 8;
  localparam int WAIT_W                 = 16;
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;
endpackage

// File: rtl/bus_copy_dma.sv
// Byte-at-a-time bus copy engine: read one byte from src, write it to dst, repeat.
// Every output comes straight from a register; the next-state process computes them all.
module bus_copy_dma
  import bus_copy_dma_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [15:0]       length,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              rd_req,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en
);

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_src, w_src_next;
  logic [ADDR_W-1:0]   r_dst, w_dst_next;
  logic [15:0]         r_remaining, w_remaining_next;
  logic [WAIT_W-1:0]   r_wait, w_wait_next;
  logic                r_busy, w_busy_next;
  logic                r_done, w_done_next;
  logic                r_error, w_error_next;
  logic [ADDR_W-1:0]   r_bus_addr, w_bus_addr_next;
  logic                r_rd_req, w_rd_req_next;
  logic [DATA_W-1:0]   r_wr_data, w_wr_data_next;
  logic                r_wr_en, w_wr_en_next;
  logic                w_timeout;

  // Last waiting cycle: the counter is about to reach TIMEOUT_CYCLES.
  assign w_timeout = (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_remaining <= '0;
      r_wait      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_bus_addr  <= '0;
      r_rd_req    <= 1'b0;
      r_wr_data   <= '0;
      r_wr_en     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_src       <= w_src_next;
      r_dst       <= w_dst_next;
      r_remaining <= w_remaining_next;
      r_wait      <= w_wait_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_error     <= w_error_next;
      r_bus_addr  <= w_bus_addr_next;
      r_rd_req    <= w_rd_req_next;
      r_wr_data   <= w_wr_data_next;
      r_wr_en     <= w_wr_en_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_src_next       = r_src;
    w_dst_next       = r_dst;
    w_remaining_next = r_remaining;
    w_wait_next      = r_wait;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_error_next     = 1'b0;
    w_bus_addr_next  = r_bus_addr;
    w_rd_req_next    = 1'b0;
    w_wr_data_next   = r_wr_data;
    w_wr_en_next     = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          if (length != 16'd0) begin
            w_src_next       = src_addr;
            w_dst_next       = dst_addr;
            w_remaining_next = length;
            w_wait_next      = '0;
            w_busy_next      = 1'b1;
            w_rd_req_next    = 1'b1;
            w_bus_addr_next  = src_addr;
            w_state_next     = READ;
          end else begin
            w_done_next  = 1'b1;
            w_busy_next  = 1'b0;
            w_state_next = FINISH;
          end
        end
      end

      READ: begin
        // An ack on the final waiting cycle still wins over the timeout.
        if (rd_ack) begin
          w_wr_data_next  = rd_data;
          w_bus_addr_next = r_dst;
          w_wr_en_next    = 1'b1;
          w_state_next    = WRITE;
        end else if (w_timeout) begin
          w_done_next  = 1'b1;
          w_error_next = 1'b1;
          w_busy_next  = 1'b0;
          w_state_next = FINISH;
        end else begin
          w_wait_next   = r_wait + WAIT_W'(1);
          w_rd_req_next = 1'b1;
        end
      end

      WRITE: begin
        w_src_next       = r_src + ADDR_W'(1);
        w_dst_next       = r_dst + ADDR_W'(1);
        w_remaining_next = r_remaining - 16'd1;
        if (r_remaining == 16'd1) begin
          w_done_next  = 1'b1;
          w_busy_next  = 1'b0;
          w_state_next = FINISH;
        end else begin
          // rd_req was low during this WRITE cycle, giving the gap between reads.
          w_wait_next     = '0;
          w_rd_req_next   = 1'b1;
          w_bus_addr_next = r_src + ADDR_W'(1);
          w_state_next    = READ;
        end
      end

      FINISH: begin
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign bus_addr = r_bus_addr;
  assign rd_req   = r_rd_req;
  assign wr_data  = r_wr_data;
  assign wr_en    = r_wr_en;

endmodule

// File: tb/tb_bus_copy_dma.sv
// Directed bench for bus_copy_dma: a latency-3 read responder plus bus monitor in one linear sequence.
module tb_bus_copy_dma;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] bus_addr;
  logic        rd_req;
  logic        rd_ack;
  logic [7:0]  rd_data;
  logic [7:0]  wr_data;
  logic        wr_en;

  bus_copy_dma #(.TIMEOUT_CYCLES(8)) dut (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .bus_addr (bus_addr),
    .rd_req   (rd_req),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .wr_data  (wr_data),
    .wr_en    (wr_en)
  );

  always #5 sys_clk = ~sys_clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] rd_addr_q[$];
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          rreq_cycles, rreq_rises, busy_cycles, done_cnt, done_cyc;
  logic        err_at_done, busy_at_done, rreq_at_done, busy_first, prev_rreq;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // mode 0: responder acks 3 cycles after rd_req rises; 1: never acks;
  // 2: as 0 plus stray rd_ack on write cycles and start pokes in READ/WRITE/FINISH.
  task automatic do_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                         input int mode, input int stop_at_wr);
    int lat;
    lat = 0;
    rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    rreq_cycles = 0; rreq_rises = 0; busy_cycles = 0; done_cnt = 0; done_cyc = -1;
    err_at_done = 1'bx; busy_at_done = 1'bx; rreq_at_done = 1'bx; busy_first = 1'bx;
    prev_rreq = 1'b0;
    src_addr = s; dst_addr = d; length = n; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 1) busy_first = busy;
      if (rd_req) begin
        rreq_cycles++;
        if (!prev_rreq) rreq_rises++;
      end
      prev_rreq = rd_req;
      if (busy) busy_cycles++;
      if (wr_en) begin
        wr_addr_q.push_back(bus_addr);
        wr_data_q.push_back(wr_data);
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = c; err_at_done = error; busy_at_done = busy; rreq_at_done = rd_req;
        end
      end
      rd_ack = 1'b0;
      rd_data = 8'h00;
      if (stop_at_wr != 0 && wr_addr_q.size() == stop_at_wr) break;
      if (done_cnt > 0 && c >= done_cyc + 3) break;
      if (rd_req && mode != 1) begin
        lat++;
        if (lat == 4) begin
          rd_ack = 1'b1;
          rd_data = pat(bus_addr);
          rd_addr_q.push_back(bus_addr);
          lat = 0;
        end
      end else begin
        lat = 0;
      end
      if (mode == 2) begin
        if (wr_en) begin
          rd_ack = 1'b1;
          rd_data = 8'hEE;
        end
        start = (c == 3 || c == 5 || (done && done_cnt == 1));
        src_addr = 16'hDEAD; dst_addr = 16'hBEEF; length = 16'h0007;
      end
      @(posedge sys_clk); #1;
    end
    rd_ack = 1'b0;
    start = 1'b0;
  endtask

  task automatic chk_copy(input string tag, input logic [15:0] s, input logic [15:0] d,
                          input int n, input int exp_done);
    logic [15:0] ea;
    logic [31:0] obs;
    chk({tag, "_nreads"}, rd_addr_q.size(), n);
    chk({tag, "_nwrites"}, wr_addr_q.size(), n);
    for (int i = 0; i < n; i++) begin
      ea = s + 16'(i);
      obs = (i < rd_addr_q.size()) ? {16'h0, rd_addr_q[i]} : 32'hFFFF_FFFF;
      chk($sformatf("%s_raddr%0d", tag, i), obs, {16'h0, ea});
      obs = (i < wr_data_q.size()) ? {24'h0, wr_data_q[i]} : 32'hFFFF_FFFF;
      chk($sformatf("%s_wdata%0d", tag, i), obs, {24'h0, pat(ea)});
      ea = d + 16'(i);
      obs = (i < wr_addr_q.size()) ? {16'h0, wr_addr_q[i]} : 32'hFFFF_FFFF;
      chk($sformatf("%s_waddr%0d", tag, i), obs, {16'h0, ea});
    end
    chk({tag, "_done_cyc"}, done_cyc, exp_done);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_error"}, err_at_done, 1'b0);
    chk({tag, "_busy_at_done"}, busy_at_done, 1'b0);
    chk({tag, "_busy_first"}, busy_first, 1'b1);
    chk({tag, "_busy_cycles"}, busy_cycles, exp_done - 1);
    chk({tag, "_rreq_rises"}, rreq_rises, n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
    chk({tag, "_rd_req"}, rd_req, 1'b0);
    chk({tag, "_wr_en"}, wr_en, 1'b0);
    chk({tag, "_bus_addr"}, bus_addr, 16'h0000);
    chk({tag, "_wr_data"}, wr_data, 8'h00);
  endtask

  initial begin
    int seen_done, seen_rreq;
    reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    rd_ack = 1'b0; rd_data = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(posedge sys_clk); #1;

    // Four-byte copy, 5 cycles per byte, done visible 21 cycles after the start edge.
    do_copy(16'h1000, 16'h2000, 16'd4, 0, 0);
    chk_copy("copy4", 16'h1000, 16'h2000, 4, 21);
    $display("copy4: src=0x1000 dst=0x2000 len=4 done_cyc=%0d", done_cyc);

    // Zero length: straight to FINISH, no bus activity, busy never rises.
    do_copy(16'h1234, 16'h5678, 16'd0, 0, 0);
    chk("len0_done_cyc", done_cyc, 1);
    chk("len0_done_cnt", done_cnt, 1);
    chk("len0_error", err_at_done, 1'b0);
    chk("len0_rreq_cycles", rreq_cycles, 0);
    chk("len0_writes", wr_addr_q.size(), 0);
    chk("len0_busy_cycles", busy_cycles, 0);
    $display("len0: done_cyc=%0d", done_cyc);

    // Address wrap at 0xFFFF on both pointers.
    do_copy(16'hFFFE, 16'hFFFF, 16'd3, 0, 0);
    chk_copy("wrap", 16'hFFFE, 16'hFFFF, 3, 16);
    $display("wrap: src=0xFFFE dst=0xFFFF len=3 done_cyc=%0d", done_cyc);

    // No responder: rd_req high for 8 cycles, then done+error together.
    do_copy(16'h0100, 16'h0200, 16'd2, 1, 0);
    chk("tmo_rreq_cycles", rreq_cycles, 8);
    chk("tmo_rreq_rises", rreq_rises, 1);
    chk("tmo_done_cyc", done_cyc, 9);
    chk("tmo_done_cnt", done_cnt, 1);
    chk("tmo_error", err_at_done, 1'b1);
    chk("tmo_rreq_at_done", rreq_at_done, 1'b0);
    chk("tmo_writes", wr_addr_q.size(), 0);
    $display("timeout: rreq_cycles=%0d done_cyc=%0d error=%0b", rreq_cycles, done_cyc, err_at_done);

    // Reset while the second of four writes is on the bus.
    do_copy(16'h0A00, 16'h0B00, 16'd4, 0, 2);
    chk("rst_mid_writes_before", wr_addr_q.size(), 2);
    reset_n = 1'b0;
    @(posedge sys_clk); #1;
    chk_all_zero("rst_mid");
    reset_n = 1'b1;
    seen_done = 0; seen_rreq = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge sys_clk); #1;
      if (done) seen_done++;
      if (rd_req || wr_en) seen_rreq++;
    end
    chk("rst_mid_no_done", seen_done, 0);
    chk("rst_mid_quiet_bus", seen_rreq, 0);
    $display("reset_mid: done_after=%0d bus_activity=%0d", seen_done, seen_rreq);
    do_copy(16'h3000, 16'h4000, 16'd2, 0, 0);
    chk_copy("post_rst", 16'h3000, 16'h4000, 2, 11);
    $display("post_reset copy: src=0x3000 dst=0x4000 len=2 done_cyc=%0d", done_cyc);

    // Start pokes in READ, WRITE and FINISH plus stray acks on write cycles change nothing.
    do_copy(16'h0500, 16'h0600, 16'd3, 2, 0);
    chk_copy("ignore", 16'h0500, 16'h0600, 3, 16);
    chk("ignore_busy_after", busy, 1'b0);
    $display("ignore: src=0x0500 dst=0x0600 len=3 done_cyc=%0d done_cnt=%0d", done_cyc, done_cnt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
